// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared M-op funct3 encodings and FSM state type for the EX-stage multiply/divide unit.
package muldiv_pkg;
    typedef enum logic [2:0] {
        F_MUL    = 3'd0,
        F_MULH   = 3'd1,
        F_MULHSU = 3'd2,
        F_MULHU  = 3'd3,
        F_DIV    = 3'd4,
        F_DIVU   = 3'd5,
        F_REM    = 3'd6,
        F_REMU   = 3'd7
    } funct3_e;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
    localparam logic [5:0] LAST_ITER = 6'd31;
endpackage

// File: rtl/muldiv_ex_if.sv
// muldiv_ex_if: EX-stage handshake and operand/result bus between pipeline (master) and M-unit (slave).
interface muldiv_ex_if #(parameter int XLEN = 32);
    logic            StartE;
    logic [2:0]      funct3E;
    logic [XLEN-1:0] rs1E;
    logic [XLEN-1:0] rs2E;
    logic            Abort;
    logic            BusyE;
    logic            DoneE;
    logic [XLEN-1:0] MulDivResultE;
    modport master (output StartE, funct3E, rs1E, rs2E, Abort, input BusyE, DoneE, MulDivResultE);
    modport slave (input StartE, funct3E, rs1E, rs2E, Abort, output BusyE, DoneE, MulDivResultE);
endinterface

// File: rtl/div_core.sv
// div_core: restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle over W iterations.
module div_core #(parameter int W = 32) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);
    localparam int CW = $clog2(W);
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
    logic [W:0]    shl, diff;
    assign shl  = {rem_q, quo_q[W-1]};
    assign diff = shl - {1'b0, dsr_q};
    // done marks the cycle whose closing edge performs the final iteration
    assign done = busy_q && cnt_q == CW'(W - 1);
    assign quot = quo_q;
    assign rem  = rem_q;
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dsr_d  = dsr_q;
        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = dividend;
            dsr_d  = divisor;
        end else if (busy_q) begin
            rem_d  = diff[W] ? shl[W-1:0] : diff[W-1:0];
            quo_d  = {quo_q[W-2:0], ~diff[W]};
            cnt_d  = cnt_q + CW'(1);
            busy_d = !done;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dsr_q  <= dsr_d;
        end
    end
endmodule

// File: rtl/muldiv_ex.sv
// muldiv_ex: iterative RV32M multiply/divide unit for the EX stage; shift-add multiply here, division in div_core.
module muldiv_ex
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    muldiv_ex_if.slave bus
);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    state_e            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic              qneg_q, qneg_d, rneg_q, rneg_d, sp_q, sp_d;
    logic              a_neg, b_neg, dz, ovf, go, fin, div_start, div_done;
    logic [XLEN-1:0]   a_mag, b_mag, spv, quot, rem, q_res, r_res, res;
    logic [2*XLEN-1:0] p_res;
    logic [XLEN:0]     acc;
    assign a_neg = (bus.funct3E inside {F_MULH, F_MULHSU, F_DIV, F_REM}) && bus.rs1E[XLEN-1];
    assign b_neg = (bus.funct3E inside {F_MULH, F_DIV, F_REM}) && bus.rs2E[XLEN-1];
    assign a_mag = a_neg ? -bus.rs1E : bus.rs1E;
    assign b_mag = b_neg ? -bus.rs2E : bus.rs2E;
    assign dz    = bus.funct3E[2] && bus.rs2E == '0;
    assign ovf   = (bus.funct3E inside {F_DIV, F_REM}) && bus.rs1E == INT_MIN && bus.rs2E == '1;
    // corner cases bypass iteration; their result is parked in prod_q low half
    assign spv   = ovf ? (bus.funct3E[1] ? {XLEN{1'b0}} : INT_MIN) : (bus.funct3E[1] ? bus.rs1E : {XLEN{1'b1}});
    assign go        = state_q == S_IDLE && bus.StartE && !bus.Abort;
    assign div_start = go && bus.funct3E[2] && !dz && !ovf;
    assign fin       = f3_q[2] ? div_done : cnt_q == LAST_ITER;
    assign acc   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    assign p_res = qneg_q ? -prod_q : prod_q;
    assign q_res = qneg_q ? -quot : quot;
    assign r_res = rneg_q ? -rem : rem;
    assign res   = sp_q ? prod_q[XLEN-1:0] :
                   f3_q[2] ? (f3_q[1] ? r_res : q_res) :
                   (f3_q == F_MUL ? p_res[XLEN-1:0] : p_res[2*XLEN-1:XLEN]);
    assign bus.BusyE         = go || state_q == S_CALC;
    assign bus.DoneE         = state_q == S_DONE;
    assign bus.MulDivResultE = state_q == S_DONE ? res : {XLEN{1'b0}};
    div_core #(.W(XLEN)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .abort    (bus.Abort),
        .dividend (a_mag),
        .divisor  (b_mag),
        .done     (div_done),
        .quot     (quot),
        .rem      (rem)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        sp_d    = sp_q;
        if (bus.Abort) begin
            state_d = S_IDLE;
        end else if (go) begin
            f3_d    = bus.funct3E;
            cnt_d   = '0;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            sp_d    = dz || ovf;
            mcand_d = a_mag;
            prod_d  = {{XLEN{1'b0}}, (dz || ovf) ? spv : b_mag};
            state_d = (dz || ovf) ? S_DONE : S_CALC;
        end else if (state_q == S_CALC) begin
            prod_d  = {acc, prod_q[XLEN-1:1]};
            cnt_d   = cnt_q + 6'd1;
            state_d = fin ? S_DONE : S_CALC;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            sp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            sp_q    <= sp_d;
        end
    end
endmodule

// File: doc/muldiv_ex.md
MULDIV_EX -- requirements
Module: muldiv_ex

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the operand and result width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port StartE, input, 1 bit: the EX-stage instruction is an RV32M op.
REQ-005 The block SHALL have port funct3E, input, 3 bits: M-op select (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-006 The block SHALL have ports rs1E and rs2E, input, 32 bits each: the forwarded operands A and B.
REQ-007 The block SHALL have port Abort, input, 1 bit: cancel any in-flight operation.
REQ-008 The block SHALL have port BusyE, output, 1 bit: stall request to the hazard unit.
REQ-009 The block SHALL have port DoneE, output, 1 bit: result valid this cycle.
REQ-010 The block SHALL have port MulDivResultE, output, 32 bits: the result, valid only while DoneE=1.

Function
REQ-011 The block SHALL implement the FSM states IDLE, CALC and DONE.
REQ-012 In IDLE with StartE=1 and Abort=0, the block SHALL latch the operands, funct3 and operand-sign info, clear the iteration count to 0, and go to CALC.
- Exception: divide-by-zero or signed overflow goes directly to DONE (see REQ-019, REQ-020).
REQ-013 In CALC, the block SHALL perform one radix-2 iteration per cycle (shift-add for multiply, restoring shift-subtract for divide) on operand magnitudes, for exactly 32 cycles, then go to DONE.
REQ-014 In DONE, the block SHALL assert DoneE=1, drive the result, ignore StartE, and return to IDLE on the next edge.
REQ-015 The block SHALL drive BusyE = (IDLE and StartE and not Abort) or CALC.
- BusyE SHALL be 0 in DONE, so the pipeline advances exactly once per M-op.
REQ-016 Normal latency SHALL be 34 cycles from StartE seen in IDLE to DoneE=1: 1 IDLE cycle, 32 CALC cycles, then DONE on the next cycle.
REQ-017 Multiply SHALL form a 64-bit product with the following outputs:
- MUL returns bits [31:0].
- MULH (signed x signed), MULHSU (signed x unsigned) and MULHU (unsigned x unsigned) return bits [63:32].
- Signed operands SHALL be converted to magnitude, and the product negated when the operand signs differ.
REQ-018 For signed division, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-019 Divide by zero SHALL return all-ones for DIV/DIVU and the dividend for REM/REMU, with latency 2 (IDLE, then DONE).
REQ-020 Signed overflow (A=0x80000000, B=0xFFFFFFFF) SHALL return 0x80000000 for DIV and 0 for REM, with latency 2.
REQ-021 Abort=1 in any state SHALL force IDLE on the next edge, with no DoneE for the aborted op.
- Abort SHALL take priority over StartE.
REQ-022 The block SHALL drive DoneE=0 and MulDivResultE=0 in every state other than DONE.
REQ-023 Operand changes on rs1E/rs2E while in CALC or DONE SHALL have no effect on the result.

Reset
REQ-024 Asserting rst SHALL immediately force IDLE, with BusyE=0 (given StartE=0), DoneE=0, MulDivResultE=0, all datapath registers 0 and the count 0.
REQ-025 rst asserted mid-operation SHALL discard that operation, with no DoneE afterwards.
REQ-026 After rst deasserts, the first rising edge SHALL accept StartE normally.

Structure
REQ-027 The M-op funct3 encodings and the FSM state enum SHALL live in the shared package muldiv_pkg.
REQ-028 The divide datapath SHALL be a sub-module, div_core: a restoring divider with start/done handshake and a 32-iteration count.
- The multiply datapath SHALL stay in muldiv_ex.

Verification
REQ-029 The bench SHALL cover MUL: A=7, B=-3, StartE held -> BusyE=1 for 33 cycles, then DoneE=1 with result 0xFFFFFFEB.
REQ-030 The bench SHALL cover MULHU: A=B=0xFFFFFFFF -> result 0xFFFFFFFE at cycle 34; the same operands with MULH -> 0x00000000.
REQ-031 The bench SHALL cover DIV and REM: A=-7, B=2 -> DIV result 0xFFFFFFFD and REM result 0xFFFFFFFF, each with latency 34.
REQ-032 The bench SHALL cover divide by zero: DIVU A=5, B=0 -> 0xFFFFFFFF, and REMU -> 5, with DoneE at cycle 2; overflow DIV -> 0x80000000 at cycle 2.
REQ-033 The bench SHALL cover Abort at CALC cycle 10 -> IDLE next edge, BusyE=0, no DoneE; an immediate new op then completes correctly.
REQ-034 The bench SHALL cover rst pulsed mid-CALC -> outputs 0 asynchronously, no DoneE; back-to-back ops with StartE held through DONE -> exactly one DoneE per op.
